i2c_regfile_responder: RTL and testbench

I2C slave (responder) with an internal 256 x 8 register file, modelling the ADV7513 control port that our I2C initiator (`adv7513_init`, `adv7513_reg_read`) talks to. It samples SCL/SDA on the system clock, decodes START/STOP, matches a 7-bit device address, and supports pointer-based multi-byte writes and reads with auto-increment. It is used as the HDMI-transmitter stand-in in simulation and as a loopback target on the board, with an open-drain SDA driver and a side port so the bench can inspect register contents.

---
 rtl/i2c_regfile_responder.sv | 209 ++++++++++++++++++++
 tb/tb_i2c_regfile_responder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_regfile_responder.sv
// I2C responder with a 256 x 8 register file; register 0x00 always reads CHIP_REV and ignores writes.
// Pointer-based multi-byte writes and reads with 8-bit wrapping auto-increment, open-drain SDA.
module i2c_regfile_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h39,
  parameter logic [7:0] CHIP_REV = 8'h13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t     state, state_n;
  logic       scl_s1, scl_s2, scl_h;
  logic       sda_s1, sda_s2, sda_h;
  logic [2:0] cnt, cnt_n;
  logic [7:0] shift, shift_n;
  logic [7:0] ptr, ptr_n;
  logic       rw, rw_n;
  logic       sda_oe_n, busy_n;
  logic       reg_we;
  logic [7:0] reg_wa, reg_wd;
  logic [7:0] regs [256];
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] bit_in, rd_byte;

  assign scl_rise  = scl_s2 & ~scl_h;
  assign scl_fall  = ~scl_s2 & scl_h;
  assign start_det = scl_s2 & scl_h & sda_h & ~sda_s2;
  assign stop_det  = scl_s2 & scl_h & ~sda_h & sda_s2;
  assign bit_in    = {shift[6:0], sda_s2};
  assign rd_byte   = (ptr == 8'h00) ? CHIP_REV : regs[ptr];
  assign dbg_data  = (dbg_addr == 8'h00) ? CHIP_REV : regs[dbg_addr];

  always_ff @(posedge clock) begin
    if (!reset) begin
      scl_s1    <= 1'b1;
      scl_s2    <= 1'b1;
      scl_h     <= 1'b1;
      sda_s1    <= 1'b1;
      sda_s2    <= 1'b1;
      sda_h     <= 1'b1;
      state     <= IDLE;
      cnt       <= 3'd7;
      shift     <= 8'h00;
      ptr       <= 8'h00;
      rw        <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 8'h00;
      wr_data   <= 8'h00;
      for (int i = 0; i < 256; i++) regs[i] <= 8'h00;
    end else begin
      scl_s1    <= scl_in;
      scl_s2    <= scl_s1;
      scl_h     <= scl_s2;
      sda_s1    <= sda_in;
      sda_s2    <= sda_s1;
      sda_h     <= sda_s2;
      state     <= state_n;
      cnt       <= cnt_n;
      shift     <= shift_n;
      ptr       <= ptr_n;
      rw        <= rw_n;
      sda_oe    <= sda_oe_n;
      busy      <= busy_n;
      wr_strobe <= reg_we;
      if (reg_we) begin
        regs[reg_wa] <= reg_wd;
        wr_addr      <= reg_wa;
        wr_data      <= reg_wd;
      end
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    shift_n  = shift;
    ptr_n    = ptr;
    rw_n     = rw;
    sda_oe_n = sda_oe;
    busy_n   = busy;
    reg_we   = 1'b0;
    reg_wa   = ptr;
    reg_wd   = bit_in;

    if (start_det) begin
      state_n  = ADDR;
      cnt_n    = 3'd7;
      sda_oe_n = 1'b0;
    end else if (stop_det) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise) begin
            shift_n = bit_in;
            if (cnt == 3'd0) begin
              if (bit_in[7:1] == DEV_ADDR) begin
                state_n = ADDR_ACK;
                rw_n    = bit_in[0];
                busy_n  = 1'b1;
              end else begin
                state_n = WAIT_STOP;
                busy_n  = 1'b0;
              end
            end else begin
              cnt_n = cnt - 3'd1;
            end
          end
        end
        // sda_oe doubles as the ACK phase flag: first fall drives ACK, second ends it.
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_n = 1'b1;
            end else if (rw) begin
              state_n  = RDATA;
              shift_n  = rd_byte;
              sda_oe_n = ~rd_byte[7];
              cnt_n    = 3'd7;
            end else begin
              state_n  = PTR;
              sda_oe_n = 1'b0;
              cnt_n    = 3'd7;
            end
          end
        end
        PTR: begin
          if (scl_rise) begin
            shift_n = bit_in;
            if (cnt == 3'd0) begin
              ptr_n   = bit_in;
              state_n = PTR_ACK;
            end else begin
              cnt_n = cnt - 3'd1;
            end
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_n = 1'b1;
            end else begin
              sda_oe_n = 1'b0;
              state_n  = WDATA;
              cnt_n    = 3'd7;
            end
          end
        end
        WDATA: begin
          if (scl_rise) begin
            shift_n = bit_in;
            if (cnt == 3'd0) begin
              reg_we  = (ptr != 8'h00);
              ptr_n   = ptr + 8'd1;
              state_n = WDATA_ACK;
            end else begin
              cnt_n = cnt - 3'd1;
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            if (cnt == 3'd0) begin
              state_n = RD_ACK;
              ptr_n   = ptr + 8'd1;
            end else begin
              cnt_n = cnt - 3'd1;
            end
          end else if (scl_fall) begin
            sda_oe_n = ~shift[cnt];
          end
        end
        RD_ACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
          end else if (scl_rise) begin
            if (!sda_s2) begin
              state_n = RDATA;
              shift_n = rd_byte;
              cnt_n   = 3'd7;
            end else begin
              state_n = WAIT_STOP;
              busy_n  = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_regfile_responder.sv
// Bench for i2c_regfile_responder: bit-banged I2C initiator on an open-drain bus,
// checked against an array-based register/pointer model.
module tb_i2c_regfile_responder;
  localparam int Q = 100;
  localparam logic [7:0] CHIP_REV = 8'h13;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic [7:0] dbg_addr = 8'h00;
  logic       sda_oe, wr_strobe, busy;
  logic [7:0] dbg_data, wr_addr, wr_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  m_regs [256];
  logic [7:0]  m_ptr;
  logic [15:0] strobes[$];
  logic [15:0] exp_strobes[$];

  logic       oe_seen = 1'b0;
  logic       busy_seen = 1'b0;
  int         oe_viol = 0;
  logic       prev_oe = 1'b0;
  logic [4:0] hist = 5'b11111;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clock = ~clock;

  i2c_regfile_responder dut (
    .clock(clock), .reset(reset), .scl_in(scl), .sda_in(sda_line), .sda_oe(sda_oe),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always @(negedge clock) begin
    if (wr_strobe) strobes.push_back({wr_addr, wr_data});
    if (sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (reset && (sda_oe !== prev_oe) && (hist == 5'b11111)) oe_viol++;
    prev_oe = sda_oe;
    hist = {hist[3:0], scl};
  end

  // reference model
  function automatic void m_clear();
    for (int i = 0; i < 256; i++) m_regs[i] = 8'h00;
    m_ptr = 8'h00;
  endfunction

  function automatic void m_write(input logic [7:0] d);
    if (m_ptr != 8'h00) begin
      m_regs[m_ptr] = d;
      exp_strobes.push_back({m_ptr, d});
    end
    m_ptr = m_ptr + 8'd1;
  endfunction

  function automatic logic [7:0] m_read();
    logic [7:0] v;
    v = (m_ptr == 8'h00) ? CHIP_REV : m_regs[m_ptr];
    m_ptr = m_ptr + 8'd1;
    return v;
  endfunction

  // bus initiator
  task automatic i2c_start();
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; b = sda_line; #Q; scl = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic recv_byte(input logic give_ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(~give_ack);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (5) @(negedge clock);
    n_checks++; if (sda_oe !== 1'b0) begin n_errors++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (wr_strobe !== 1'b0) begin n_errors++; $display("FAIL reset_wr_strobe got %b want 0", wr_strobe); end
    n_checks++; if ({wr_addr, wr_data} !== 16'h0000) begin n_errors++; $display("FAIL reset_wr_bus got %h want 0000", {wr_addr, wr_data}); end
    reset = 1'b1;
    repeat (5) @(negedge clock);
    dbg_addr = 8'h00; #1;
    n_checks++; if (dbg_data !== CHIP_REV) begin n_errors++; $display("FAIL reset_chip_rev got %h want %h", dbg_data, CHIP_REV); end
    dbg_addr = 8'($urandom_range(1, 255)); #1;
    n_checks++; if (dbg_data !== 8'h00) begin n_errors++; $display("FAIL reset_reg[%h] got %h want 00", dbg_addr, dbg_data); end
    m_clear();
  endtask

  task automatic test_basic_write();
    logic ack;
    logic [7:0] bytes [3];
    bytes = '{8'h72, 8'h41, 8'h10};
    strobes.delete(); exp_strobes.delete();
    i2c_start();
    for (int i = 0; i < 3; i++) begin
      send_byte(bytes[i], ack);
      n_checks++; if (ack !== 1'b1) begin n_errors++; $display("FAIL basic_ack%0d got %b want 1", i, ack); end
      if (i == 0) begin
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL basic_busy_mid got %b want 1", busy); end
      end
    end
    i2c_stop();
    m_ptr = 8'h41; m_write(8'h10);
    #Q;
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL basic_busy_after_stop got %b want 0", busy); end
    n_checks++; if (strobes.size() !== exp_strobes.size()) begin n_errors++; $display("FAIL basic_strobe_count got %0d want %0d", strobes.size(), exp_strobes.size()); end
    else foreach (exp_strobes[i]) begin
      n_checks++; if (strobes[i] !== exp_strobes[i]) begin n_errors++; $display("FAIL basic_strobe%0d got %h want %h", i, strobes[i], exp_strobes[i]); end
    end
    dbg_addr = 8'h41; #1;
    n_checks++; if (dbg_data !== 8'h10) begin n_errors++; $display("FAIL basic_dbg41 got %h want 10", dbg_data); end
  endtask

  task automatic test_wrap_write();
    logic ack;
    logic [7:0] d;
    logic [7:0] bytes [5];
    bytes = '{8'h72, 8'hFE, 8'hAA, 8'hBB, 8'hCC};
    i2c_start();
    send_byte(8'h72, ack); send_byte(8'h01, ack); send_byte(8'h66, ack);
    i2c_stop();
    m_ptr = 8'h01; m_write(8'h66);
    strobes.delete(); exp_strobes.delete();
    i2c_start();
    for (int i = 0; i < 5; i++) begin
      send_byte(bytes[i], ack);
      n_checks++; if (ack !== 1'b1) begin n_errors++; $display("FAIL wrap_ack%0d got %b want 1", i, ack); end
    end
    i2c_stop();
    m_ptr = 8'hFE; m_write(8'hAA); m_write(8'hBB); m_write(8'hCC);
    #Q;
    n_checks++; if (strobes.size() !== exp_strobes.size()) begin n_errors++; $display("FAIL wrap_strobe_count got %0d want %0d", strobes.size(), exp_strobes.size()); end
    else foreach (exp_strobes[i]) begin
      n_checks++; if (strobes[i] !== exp_strobes[i]) begin n_errors++; $display("FAIL wrap_strobe%0d got %h want %h", i, strobes[i], exp_strobes[i]); end
    end
    for (int a = 254; a <= 256; a++) begin
      dbg_addr = 8'(a); #1;
      n_checks++;
      if (dbg_data !== ((dbg_addr == 8'h00) ? CHIP_REV : m_regs[dbg_addr])) begin
        n_errors++; $display("FAIL wrap_dbg[%h] got %h want %h", dbg_addr, dbg_data, (dbg_addr == 8'h00) ? CHIP_REV : m_regs[dbg_addr]);
      end
    end
    // current-address read shows where the pointer landed
    i2c_start();
    send_byte(8'h73, ack);
    recv_byte(1'b0, d);
    i2c_stop();
    n_checks++; if (d !== m_read()) begin n_errors++; $display("FAIL wrap_ptr_read got %h want %h", d, m_regs[8'h01]); end
  endtask

  task automatic test_ptr_then_read();
    logic ack;
    logic [7:0] d, e;
    i2c_start();
    send_byte(8'h72, ack);
    n_checks++; if (ack !== 1'b1) begin n_errors++; $display("FAIL ptrrd_ack_w got %b want 1", ack); end
    send_byte(8'h00, ack);
    n_checks++; if (ack !== 1'b1) begin n_errors++; $display("FAIL ptrrd_ack_ptr got %b want 1", ack); end
    m_ptr = 8'h00;
    i2c_start();
    send_byte(8'h73, ack);
    n_checks++; if (ack !== 1'b1) begin n_errors++; $display("FAIL ptrrd_ack_r got %b want 1", ack); end
    recv_byte(1'b1, d); e = m_read();
    n_checks++; if (d !== e) begin n_errors++; $display("FAIL ptrrd_byte0 got %h want %h", d, e); end
    recv_byte(1'b0, d); e = m_read();
    n_checks++; if (d !== e) begin n_errors++; $display("FAIL ptrrd_byte1 got %h want %h", d, e); end
    n_checks++; if (sda_oe !== 1'b0) begin n_errors++; $display("FAIL ptrrd_released got %b want 0", sda_oe); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL ptrrd_busy_nack got %b want 0", busy); end
    i2c_stop();
  endtask

  task automatic test_random();
    logic ack;
    logic [7:0] p, d, e;
    int n;
    for (int it = 0; it < 6; it++) begin
      p = 8'($urandom_range(0, 255));
      if (it == 0) p = 8'hFD;
      n = $urandom_range(1, 4);
      strobes.delete(); exp_strobes.delete();
      i2c_start();
      send_byte(8'h72, ack);
      send_byte(p, ack);
      m_ptr = p;
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom);
        send_byte(d, ack);
        n_checks++; if (ack !== 1'b1) begin n_errors++; $display("FAIL rnd%0d_wack%0d got %b want 1", it, k, ack); end
        m_write(d);
      end
      i2c_stop();
      #Q;
      n_checks++; if (strobes.size() !== exp_strobes.size()) begin n_errors++; $display("FAIL rnd%0d_strobe_count got %0d want %0d", it, strobes.size(), exp_strobes.size()); end
      else foreach (exp_strobes[i]) begin
        n_checks++; if (strobes[i] !== exp_strobes[i]) begin n_errors++; $display("FAIL rnd%0d_strobe%0d got %h want %h", it, i, strobes[i], exp_strobes[i]); end
      end
      i2c_start();
      send_byte(8'h72, ack);
      send_byte(p, ack);
      m_ptr = p;
      i2c_start();
      send_byte(8'h73, ack);
      for (int k = 0; k < n; k++) begin
        recv_byte(k != n - 1, d);
        e = m_read();
        n_checks++; if (d !== e) begin n_errors++; $display("FAIL rnd%0d_read%0d got %h want %h", it, k, d, e); end
      end
      i2c_stop();
      dbg_addr = p; #1;
      n_checks++;
      if (dbg_data !== ((p == 8'h00) ? CHIP_REV : m_regs[p])) begin
        n_errors++; $display("FAIL rnd%0d_dbg[%h] got %h want %h", it, p, dbg_data, (p == 8'h00) ? CHIP_REV : m_regs[p]);
      end
    end
  endtask

  task automatic test_bad_addr();
    logic ack;
    strobes.delete();
    oe_seen = 1'b0; busy_seen = 1'b0;
    i2c_start();
    send_byte(8'h74, ack);
    n_checks++; if (ack !== 1'b0) begin n_errors++; $display("FAIL badaddr_ack got %b want 0 (no ack)", ack); end
    send_byte(8'h55, ack);
    n_checks++; if (ack !== 1'b0) begin n_errors++; $display("FAIL badaddr_data_ack got %b want 0", ack); end
    i2c_stop();
    #Q;
    n_checks++; if (oe_seen !== 1'b0) begin n_errors++; $display("FAIL badaddr_oe got %b want 0", oe_seen); end
    n_checks++; if (busy_seen !== 1'b0) begin n_errors++; $display("FAIL badaddr_busy got %b want 0", busy_seen); end
    n_checks++; if (strobes.size() !== 0) begin n_errors++; $display("FAIL badaddr_strobes got %0d want 0", strobes.size()); end
    for (int a = 0; a < 256; a++) begin
      dbg_addr = 8'(a); #1;
      n_checks++;
      if (dbg_data !== ((a == 0) ? CHIP_REV : m_regs[a])) begin
        n_errors++; $display("FAIL badaddr_reg[%h] got %h want %h", dbg_addr, dbg_data, (a == 0) ? CHIP_REV : m_regs[a]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic ack;
    logic [7:0] d, e;
    strobes.delete();
    i2c_start();
    send_byte(8'h72, ack);
    send_byte(8'h20, ack);
    send_bit(1'b1);
    send_bit(1'b1);
    sda_m = 1'b1; #Q; scl = 1'b1; #Q;
    @(negedge clock) reset = 1'b0;
    @(negedge clock);
    n_checks++; if (sda_oe !== 1'b0) begin n_errors++; $display("FAIL rstmid_sda_oe got %b want 0", sda_oe); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #Q; scl = 1'b0; #Q;
    i2c_stop();
    m_clear();
    #Q;
    n_checks++; if (strobes.size() !== 0) begin n_errors++; $display("FAIL rstmid_strobes got %0d want 0", strobes.size()); end
    for (int a = 0; a < 256; a++) begin
      dbg_addr = 8'(a); #1;
      n_checks++;
      if (dbg_data !== ((a == 0) ? CHIP_REV : m_regs[a])) begin
        n_errors++; $display("FAIL rstmid_reg[%h] got %h want %h", dbg_addr, dbg_data, (a == 0) ? CHIP_REV : m_regs[a]);
      end
    end
    i2c_start();
    send_byte(8'h73, ack);
    n_checks++; if (ack !== 1'b1) begin n_errors++; $display("FAIL rstmid_ack_after got %b want 1", ack); end
    recv_byte(1'b0, d);
    e = m_read();
    i2c_stop();
    n_checks++; if (d !== e) begin n_errors++; $display("FAIL rstmid_ptr_read got %h want %h", d, e); end
  endtask

  task automatic test_no_oe_toggle();
    n_checks++;
    if (oe_viol !== 0) begin n_errors++; $display("FAIL oe_stable_scl_high got %0d changes want 0", oe_viol); end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_wrap_write();
    test_ptr_then_read();
    test_random();
    test_bad_addr();
    test_reset_mid();
    test_no_oe_toggle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
